// File: rtl/boa_cache_line_xfer.sv
// Line-transfer engine between the cache's external-memory side and a slow word-wide memory.
// Each accepted command moves one full line word by word, as fills (memory->buffer) or writebacks (buffer->memory).
module boa_cache_line_xfer #(
  parameter int alen      = 24,
  parameter int line_size = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic                                cmd_write,
  input  logic [alen-$clog2(line_size)-3:0]   cmd_addr,
  output logic                                done,
  output logic                                lb_re,
  output logic                                lb_we,
  output logic [$clog2(line_size)-1:0]        lb_idx,
  output logic [31:0]                         lb_wdata,
  input  logic [31:0]                         lb_rdata,
  output logic                                xm_re,
  output logic                                xm_we,
  output logic [alen-3:0]                     xm_addr,
  output logic [31:0]                         xm_wdata,
  input  logic                                xm_ready,
  input  logic [31:0]                         xm_rdata
);

  localparam int agrain = $clog2(line_size) + 2;
  localparam int iwidth = $clog2(line_size);
  localparam int aw     = alen - agrain;

  localparam logic [iwidth-1:0] IDX_ZERO = {iwidth{1'b0}};
  localparam logic [iwidth-1:0] IDX_ONE  = {{(iwidth-1){1'b0}}, 1'b1};
  localparam logic [iwidth-1:0] IDX_LAST = {iwidth{1'b1}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RDBUF  = 3'd1,
    WAITRD = 3'd2,
    XMREQ  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic              write_r, write_s;
  logic [aw-1:0]     addr_r, addr_s;
  logic [iwidth-1:0] idx_r, idx_s;

  logic              cmd_ready_s;
  logic              done_s;
  logic              lb_re_s;
  logic              lb_we_s;
  logic [iwidth-1:0] lb_idx_s;
  logic [31:0]       lb_wdata_s;
  logic              xm_re_s;
  logic              xm_we_s;
  logic [alen-3:0]   xm_addr_s;
  logic [31:0]       xm_wdata_s;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_s     = state_r;
    write_s     = write_r;
    addr_s      = addr_r;
    idx_s       = idx_r;
    cmd_ready_s = cmd_ready;
    done_s      = 1'b0;
    lb_re_s     = 1'b0;
    lb_we_s     = 1'b0;
    lb_idx_s    = lb_idx;
    lb_wdata_s  = lb_wdata;
    xm_re_s     = xm_re;
    xm_we_s     = xm_we;
    xm_addr_s   = xm_addr;
    xm_wdata_s  = xm_wdata;

    case (state_r)
      IDLE: begin
        cmd_ready_s = 1'b1;
        if (cmd_valid && cmd_ready) begin
          cmd_ready_s = 1'b0;
          write_s     = cmd_write;
          addr_s      = cmd_addr;
          idx_s       = IDX_ZERO;
          if (cmd_write) begin
            state_s  = RDBUF;
            lb_re_s  = 1'b1;
            lb_idx_s = IDX_ZERO;
          end else begin
            state_s   = XMREQ;
            xm_re_s   = 1'b1;
            xm_addr_s = {cmd_addr, IDX_ZERO};
          end
        end else begin
          state_s = IDLE;
        end
      end

      RDBUF: begin
        state_s = WAITRD;
      end

      // Writeback: buffer data has arrived. Fill: this is the one idle cycle between requests.
      WAITRD: begin
        state_s   = XMREQ;
        xm_addr_s = {addr_r, idx_r};
        if (write_r) begin
          xm_we_s    = 1'b1;
          xm_wdata_s = lb_rdata;
        end else begin
          xm_re_s = 1'b1;
        end
      end

      XMREQ: begin
        if (xm_ready) begin
          xm_re_s = 1'b0;
          xm_we_s = 1'b0;
          if (!write_r) begin
            lb_we_s    = 1'b1;
            lb_idx_s   = idx_r;
            lb_wdata_s = xm_rdata;
          end else begin
            lb_we_s = 1'b0;
          end
          if (idx_r == IDX_LAST) begin
            state_s = DONE;
            done_s  = 1'b1;
          end else begin
            idx_s = idx_r + IDX_ONE;
            if (write_r) begin
              state_s  = RDBUF;
              lb_re_s  = 1'b1;
              lb_idx_s = idx_r + IDX_ONE;
            end else begin
              state_s = WAITRD;
            end
          end
        end else begin
          state_s = XMREQ;
        end
      end

      DONE: begin
        state_s     = IDLE;
        cmd_ready_s = 1'b1;
      end

      default: begin
        state_s     = IDLE;
        cmd_ready_s = 1'b1;
        xm_re_s     = 1'b0;
        xm_we_s     = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      write_r   <= 1'b0;
      addr_r    <= {aw{1'b0}};
      idx_r     <= IDX_ZERO;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
      lb_re     <= 1'b0;
      lb_we     <= 1'b0;
      lb_idx    <= IDX_ZERO;
      lb_wdata  <= 32'h0000_0000;
      xm_re     <= 1'b0;
      xm_we     <= 1'b0;
      xm_addr   <= {(alen-2){1'b0}};
      xm_wdata  <= 32'h0000_0000;
    end else begin
      state_r   <= state_s;
      write_r   <= write_s;
      addr_r    <= addr_s;
      idx_r     <= idx_s;
      cmd_ready <= cmd_ready_s;
      done      <= done_s;
      lb_re     <= lb_re_s;
      lb_we     <= lb_we_s;
      lb_idx    <= lb_idx_s;
      lb_wdata  <= lb_wdata_s;
      xm_re     <= xm_re_s;
      xm_we     <= xm_we_s;
      xm_addr   <= xm_addr_s;
      xm_wdata  <= xm_wdata_s;
    end
  end

  boa_cache_line_xfer_chk #(
    .alen (alen)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .done     (done),
    .lb_re    (lb_re),
    .lb_we    (lb_we),
    .xm_re    (xm_re),
    .xm_we    (xm_we),
    .xm_ready (xm_ready),
    .xm_addr  (xm_addr),
    .xm_wdata (xm_wdata)
  );

endmodule

// Protocol properties of the transfer engine's outputs.
module boa_cache_line_xfer_chk #(
  parameter int alen = 24
) (
  input logic            clk,
  input logic            rst,
  input logic            done,
  input logic            lb_re,
  input logic            lb_we,
  input logic            xm_re,
  input logic            xm_we,
  input logic            xm_ready,
  input logic [alen-3:0] xm_addr,
  input logic [31:0]     xm_wdata
);

  a_xm_excl : assert property (@(posedge clk) disable iff (rst) !(xm_re && xm_we));
  a_lb_excl : assert property (@(posedge clk) disable iff (rst) !(lb_re && lb_we));
  a_done_one : assert property (@(posedge clk) disable iff (rst) done |=> !done);
  a_req_hold : assert property (@(posedge clk) disable iff (rst)
    ((xm_re || xm_we) && !xm_ready) |=>
      ($stable(xm_addr) && $stable(xm_wdata) && $stable(xm_re) && $stable(xm_we)));

endmodule

// File: tb/tb_boa_cache_line_xfer.sv
// Randomized bench for boa_cache_line_xfer: a line-level model predicts every memory
// request, buffer read and buffer write, and the monitor compares the DUT against it.
module tb_boa_cache_line_xfer;

  localparam int ALEN = 24;
  localparam int LS   = 16;
  localparam int IW   = 4;
  localparam int AW   = ALEN - IW - 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic          done;
  logic          lb_re, lb_we;
  logic [IW-1:0] lb_idx;
  logic [31:0]   lb_wdata;
  logic [31:0]   lb_rdata = 32'h0;
  logic          xm_re, xm_we;
  logic [ALEN-3:0] xm_addr;
  logic [31:0]   xm_wdata;
  logic          xm_ready = 1'b0;
  logic [31:0]   xm_rdata = 32'h0;

  boa_cache_line_xfer #(.alen(ALEN), .line_size(LS)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .done(done),
    .lb_re(lb_re), .lb_we(lb_we), .lb_idx(lb_idx), .lb_wdata(lb_wdata), .lb_rdata(lb_rdata),
    .xm_re(xm_re), .xm_we(xm_we), .xm_addr(xm_addr), .xm_wdata(xm_wdata),
    .xm_ready(xm_ready), .xm_rdata(xm_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              we;
    logic [ALEN-3:0] addr;
    logic [31:0]     data;
  } txn_t;

  typedef struct {
    logic [IW-1:0] idx;
    logic [31:0]   data;
  } bw_t;

  txn_t          mq[$];
  bw_t           bq[$];
  logic [IW-1:0] rq[$];

  int n_checks = 0;
  int n_errors = 0;

  // Memory / buffer environment knobs.
  logic [31:0] rd_base = 32'h0;
  logic [31:0] rd_mul  = 32'h0;
  logic [31:0] buf_mem [LS];
  int          fixed_dly = 0;
  int          max_dly   = 0;
  bit          spur      = 0;

  bit              busy = 0;
  int              acc_cnt = 0;
  int              done_cnt = 0;
  logic [ALEN-3:0] last_addr = '0;

  bit            re_q = 0;
  logic [IW-1:0] idx_q = '0;
  int            wcnt = 0;
  int            dly = 0;
  bit            prev_done = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [ALEN-3:0] a);
    return (rd_mul * {10'b0, a}) ^ (rd_base + {28'b0, a[IW-1:0]});
  endfunction

  // Memory model drives xm_ready/xm_rdata, then the monitor compares against the line model.
  always @(negedge clk) begin
    re_q  = lb_re;
    idx_q = lb_idx;
    if (!rst && (xm_re || xm_we)) begin
      if (wcnt >= dly) begin
        xm_ready = 1'b1;
        xm_rdata = xm_re ? mem_data(xm_addr) : $urandom;
      end else begin
        xm_ready = 1'b0;
        xm_rdata = $urandom;
      end
      wcnt++;
    end else begin
      wcnt     = 0;
      dly      = (fixed_dly >= 0) ? fixed_dly : $urandom_range(0, max_dly);
      xm_ready = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      xm_rdata = $urandom;
    end

    if (!rst) begin
      check_eq("cmd_ready", cmd_ready, !busy);
      check_eq("xm_excl", xm_re & xm_we, 0);
      check_eq("lb_excl", lb_re & lb_we, 0);
      if (xm_re || xm_we) begin
        if (mq.size() == 0) check_eq("xm_unexpected", mq.size(), 1);
        else begin
          check_eq("xm_we", xm_we, mq[0].we);
          check_eq("xm_addr", xm_addr, mq[0].addr);
          if (xm_we) check_eq("xm_wdata", xm_wdata, mq[0].data);
          if (xm_ready) begin
            last_addr = xm_addr;
            void'(mq.pop_front());
          end
        end
      end
      if (lb_we) begin
        if (bq.size() == 0) check_eq("lb_we_unexpected", bq.size(), 1);
        else begin
          check_eq("lb_idx_w", lb_idx, bq[0].idx);
          check_eq("lb_wdata", lb_wdata, bq[0].data);
          void'(bq.pop_front());
        end
      end
      if (lb_re) begin
        if (rq.size() == 0) check_eq("lb_re_unexpected", rq.size(), 1);
        else begin
          check_eq("lb_idx_r", lb_idx, rq[0]);
          void'(rq.pop_front());
        end
      end
      if (done) begin
        check_eq("done_pulse", prev_done, 0);
        check_eq("done_busy", busy, 1);
        check_eq("done_remaining", mq.size() + bq.size() + rq.size(), 0);
        done_cnt++;
        busy = 0;
      end
      prev_done = done;
      if (cmd_valid && cmd_ready) begin
        for (int k = 0; k < LS; k++) begin
          txn_t t;
          t.we   = cmd_write;
          t.addr = {cmd_addr, IW'(k)};
          t.data = cmd_write ? buf_mem[k] : 32'h0;
          mq.push_back(t);
          if (cmd_write) rq.push_back(IW'(k));
          else begin
            bw_t b;
            b.idx  = IW'(k);
            b.data = mem_data(t.addr);
            bq.push_back(b);
          end
        end
        busy = 1;
        acc_cnt++;
      end
    end else begin
      prev_done = 0;
    end
  end

  // Buffer read data appears the cycle after lb_re; garbage otherwise.
  always @(posedge clk) begin
    #1;
    lb_rdata = re_q ? buf_mem[idx_q] : $urandom;
  end

  task automatic issue(input bit w, input logic [AW-1:0] a);
    int start;
    bit ok;
    start = acc_cnt;
    ok = 0;
    cmd_write = w;
    cmd_addr  = a;
    cmd_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (acc_cnt != start) begin ok = 1; break; end
    end
    check_eq("accept_timeout", ok, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (!busy && mq.size() == 0) begin ok = 1; break; end
    end
    check_eq("idle_timeout", ok, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_cmd(input bit w, input logic [AW-1:0] a);
    issue(w, a);
    cmd_valid = 1'b0;
    wait_idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cmd_ready"}, cmd_ready, 1);
    check_eq({tag, "_strobes"}, {done, lb_re, lb_we, xm_re, xm_we}, 0);
    check_eq({tag, "_lb_idx"}, lb_idx, 0);
    check_eq({tag, "_xm_addr"}, xm_addr, 0);
    check_eq({tag, "_xm_wdata"}, xm_wdata, 0);
    check_eq({tag, "_lb_wdata"}, lb_wdata, 0);
  endtask

  task automatic randomize_env();
    rd_base = $urandom;
    rd_mul  = $urandom;
    for (int k = 0; k < LS; k++) buf_mem[k] = $urandom;
  endtask

  initial begin
    int d0;
    bit ok;
    for (int k = 0; k < LS; k++) buf_mem[k] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst_init");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Fill at 0x123, memory ready immediately.
    rd_base = 32'h0000_A000; rd_mul = 32'h0; fixed_dly = 0;
    run_cmd(1'b0, 18'h00123);
    check_eq("fill_done", done_cnt, 1);
    check_eq("fill_last_addr", last_addr, 22'h00123F);

    // Writeback at 0x123, ready three cycles after each request.
    for (int k = 0; k < LS; k++) buf_mem[k] = 32'hB0 + k;
    fixed_dly = 3;
    run_cmd(1'b1, 18'h00123);
    check_eq("wb_done", done_cnt, 2);

    // Back-to-back: second command held while the first is in flight.
    fixed_dly = 1;
    issue(1'b0, 18'h00055);
    d0 = acc_cnt;
    issue(1'b1, 18'h002AA);
    cmd_valid = 1'b0;
    check_eq("b2b_second_after_done", done_cnt, 3);
    check_eq("b2b_accepts", acc_cnt - d0, 1);
    wait_idle();
    check_eq("b2b_done", done_cnt, 4);

    // Reset in the middle of a fill, while word 7 is in progress.
    fixed_dly = 2;
    rd_base = 32'h5555_0000; rd_mul = 32'h0000_0101;
    issue(1'b0, 18'h01ABC);
    cmd_valid = 1'b0;
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      if (bq.size() == 9) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    check_eq("reach_word7", ok, 1);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    mq.delete(); bq.delete(); rq.delete(); busy = 0;
    #3 rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check_eq("rst_no_done", done_cnt, d0);

    // Spurious xm_ready outside a pending request, random delays.
    spur = 1; fixed_dly = -1; max_dly = 3;
    for (int n = 0; n < 4; n++) begin
      randomize_env();
      run_cmd(1'($urandom_range(0, 1)), AW'($urandom));
    end
    check_eq("spur_done", done_cnt, d0 + 4);

    // Highest line address: word address must reach all ones without carrying out.
    spur = 0;
    randomize_env();
    run_cmd(1'b0, {AW{1'b1}});
    check_eq("max_fill_last", last_addr, {(ALEN-2){1'b1}});
    randomize_env();
    run_cmd(1'b1, {AW{1'b1}});
    check_eq("max_wb_last", last_addr, {(ALEN-2){1'b1}});

    // Random mix with occasional held-over commands.
    spur = 1;
    d0 = done_cnt;
    for (int n = 0; n < 12; n++) begin
      randomize_env();
      run_cmd(1'($urandom_range(0, 1)), AW'($urandom));
    end
    check_eq("rand_done", done_cnt, d0 + 12);
    check_eq("final_empty", mq.size() + bq.size() + rq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
